instruction_fetch: RTL and testbench

IF-stage fetch unit of the pipelined MIPS core: owns the PC, issues requests to a variable-latency instruction memory, and produces the pcAdd4IF / instructionIF pair that the IF/ID pipeline register latches. It honours the hazard unit's stall and the ID-stage branch/jump redirect. It injects a NOP bubble whenever no valid instruction is available, so IF/ID never re-latches a stale instruction.

---
 rtl/instruction_fetch_pkg.sv | 22 ++
 rtl/instruction_fetch_if.sv | 25 ++
 rtl/instruction_fetch_pc.sv | 37 +++
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants, state encodings and helpers for the IF-stage fetch unit.
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] SQUASH = 2'd2;

    typedef enum logic [1:0] {
        PC_NEXT_INC,
        PC_NEXT_REDIRECT,
        PC_NEXT_TARGET
    } pc_next_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bundle: hazard/redirect inputs, instruction-memory handshake and IF/ID outputs.
interface instruction_fetch_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady;
    logic [31:0] memData;
    logic [31:0] pcAdd4IF;
    logic [31:0] instructionIF;
    logic        fetchValid;

    modport master (
        input  stall, redirect, redirectTarget, memReady, memData,
        output memReq, memAddr, pcAdd4IF, instructionIF, fetchValid
    );

    modport slave (
        output stall, redirect, redirectTarget, memReady, memData,
        input  memReq, memAddr, pcAdd4IF, instructionIF, fetchValid
    );

endinterface

// File: rtl/instruction_fetch_pc.sv
// Program counter with load enable and a next-value mux (pc+4 / redirect / saved target).
module pc_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  pc_next_t    sel,
    input  logic [31:0] redirect_target,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] next_pc;

    // Plain 32-bit add: 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        case (sel)
            PC_NEXT_REDIRECT: next_pc = word_align(redirect_target);
            PC_NEXT_TARGET:   next_pc = target;
            default:          next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_VALUE;
        else if (load)
            pc <= next_pc;
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF-stage fetch unit: drives instruction-memory requests and the pcAdd4IF/instructionIF pair,
// injecting NOPs whenever no valid instruction is available.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    logic [1:0]  state, state_next;
    logic [31:0] instr_buf, target;
    logic [31:0] pc, pc_plus4;
    logic        pc_load, buf_load, target_load, valid;
    pc_next_t    pc_sel;

    pc_register u_pc (
        .clk             (clk),
        .reset           (reset),
        .load            (pc_load),
        .sel             (pc_sel),
        .redirect_target (bus.redirectTarget),
        .target          (target),
        .pc              (pc),
        .pc_plus4        (pc_plus4)
    );

    assign bus.memAddr  = pc;
    assign bus.pcAdd4IF = pc_plus4;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next        = state;
        pc_load           = 1'b0;
        pc_sel            = PC_NEXT_INC;
        buf_load          = 1'b0;
        target_load       = 1'b0;
        valid             = 1'b0;
        bus.memReq        = 1'b1;
        bus.instructionIF = NOP_INSTR;
        case (state)
            FETCH: begin
                valid = bus.memReady & ~bus.redirect;
                if (valid)
                    bus.instructionIF = bus.memData;
                if (bus.redirect) begin
                    if (bus.memReady) begin
                        pc_load = 1'b1;
                        pc_sel  = PC_NEXT_REDIRECT;
                    end else begin
                        // Request cannot be cancelled: remember where to go once it drains.
                        target_load = 1'b1;
                        state_next  = SQUASH;
                    end
                end else if (bus.memReady) begin
                    if (bus.stall) begin
                        buf_load   = 1'b1;
                        state_next = HOLD;
                    end else begin
                        pc_load = 1'b1;
                    end
                end
            end
            HOLD: begin
                bus.memReq = 1'b0;
                valid      = ~bus.redirect;
                if (valid)
                    bus.instructionIF = instr_buf;
                if (bus.redirect) begin
                    pc_load    = 1'b1;
                    pc_sel     = PC_NEXT_REDIRECT;
                    state_next = FETCH;
                end else if (!bus.stall) begin
                    pc_load    = 1'b1;
                    state_next = FETCH;
                end
            end
            SQUASH: begin
                target_load = bus.redirect;
                if (bus.memReady) begin
                    pc_load    = 1'b1;
                    pc_sel     = bus.redirect ? PC_NEXT_REDIRECT : PC_NEXT_TARGET;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    assign bus.fetchValid = valid;

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            instr_buf <= NOP_INSTR;
            target    <= 32'h0;
        end else begin
            state <= state_next;
            if (buf_load)
                instr_buf <= bus.memData;
            if (target_load)
                target <= word_align(bus.redirectTarget);
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vectors with literal expectations plus a
// cycle-by-cycle comparison against a behavioural fetch model.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    // Behavioural model: the unit either has a request in flight whose data it will use,
    // holds a word for a stalled pipeline, or is draining a request it must throw away.
    logic [31:0] m_pc, m_buf, m_dest;
    logic        m_has_buf, m_flushing;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc       <= 32'h0;
            m_buf      <= 32'h0;
            m_dest     <= 32'h0;
            m_has_buf  <= 1'b0;
            m_flushing <= 1'b0;
        end else if (m_flushing) begin
            if (bus.redirect)
                m_dest <= align(bus.redirectTarget);
            if (bus.memReady) begin
                m_pc       <= bus.redirect ? align(bus.redirectTarget) : m_dest;
                m_flushing <= 1'b0;
            end
        end else if (m_has_buf) begin
            if (bus.redirect) begin
                m_pc      <= align(bus.redirectTarget);
                m_has_buf <= 1'b0;
            end else if (!bus.stall) begin
                m_pc      <= m_pc + 32'd4;
                m_has_buf <= 1'b0;
            end
        end else if (bus.redirect) begin
            if (bus.memReady) begin
                m_pc <= align(bus.redirectTarget);
            end else begin
                m_flushing <= 1'b1;
                m_dest     <= align(bus.redirectTarget);
            end
        end else if (bus.memReady) begin
            if (bus.stall) begin
                m_has_buf <= 1'b1;
                m_buf     <= bus.memData;
            end else begin
                m_pc <= m_pc + 32'd4;
            end
        end
    end

    logic        e_req, e_valid;
    logic [31:0] e_instr;

    always_comb begin
        e_req   = 1'b1;
        e_valid = 1'b0;
        e_instr = 32'h0;
        if (m_flushing) begin
            e_req = 1'b1;
        end else if (m_has_buf) begin
            e_req   = 1'b0;
            e_valid = !bus.redirect;
            e_instr = bus.redirect ? 32'h0 : m_buf;
        end else begin
            e_valid = bus.memReady & !bus.redirect;
            e_instr = e_valid ? bus.memData : 32'h0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("model memReq",        {31'h0, bus.memReq},     {31'h0, e_req});
            check("model memAddr",       bus.memAddr,             m_pc);
            check("model pcAdd4IF",      bus.pcAdd4IF,            m_pc + 32'd4);
            check("model fetchValid",    {31'h0, bus.fetchValid}, {31'h0, e_valid});
            check("model instructionIF", bus.instructionIF,       e_instr);
        end
    end

    // Drive one cycle of inputs just after the edge; returns with outputs settled.
    task automatic step(input logic st, input logic rd, input logic [31:0] tg,
                        input logic rdy, input logic [31:0] dt);
        @(posedge clk);
        #1;
        bus.stall          = st;
        bus.redirect       = rd;
        bus.redirectTarget = tg;
        bus.memReady       = rdy;
        bus.memData        = dt;
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall          = 1'b0;
        bus.redirect       = 1'b0;
        bus.redirectTarget = 32'h0;
        bus.memReady       = 1'b0;
        bus.memData        = 32'h0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2;
        check("reset memReq",        {31'h0, bus.memReq},     32'h1);
        check("reset memAddr",       bus.memAddr,             32'h0);
        check("reset pcAdd4IF",      bus.pcAdd4IF,            32'h4);
        check("reset fetchValid",    {31'h0, bus.fetchValid}, 32'h0);
        check("reset instructionIF", bus.instructionIF,       32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post-reset fetchValid", {31'h0, bus.fetchValid}, 32'h0);

        // Zero-wait stream
        step(0, 0, 0, 1, 32'h2008_0001);
        check("zw0 memAddr", bus.memAddr, 32'h0);
        check("zw0 pcAdd4IF", bus.pcAdd4IF, 32'h4);
        check("zw0 instructionIF", bus.instructionIF, 32'h2008_0001);
        step(0, 0, 0, 1, 32'h2009_0002);
        check("zw1 memAddr", bus.memAddr, 32'h4);
        check("zw1 pcAdd4IF", bus.pcAdd4IF, 32'h8);
        check("zw1 fetchValid", {31'h0, bus.fetchValid}, 32'h1);
        step(0, 0, 0, 1, 32'h200A_0003);
        check("zw2 memAddr", bus.memAddr, 32'h8);
        check("zw2 pcAdd4IF", bus.pcAdd4IF, 32'hC);

        // Latency-3 memory at address 0
        do_reset();
        step(0, 0, 0, 0, 32'hBAD0_0000);
        check("lat c1 fetchValid", {31'h0, bus.fetchValid}, 32'h0);
        check("lat c1 instructionIF", bus.instructionIF, 32'h0);
        step(0, 0, 0, 0, 32'hBAD0_0001);
        check("lat c2 memAddr", bus.memAddr, 32'h0);
        check("lat c2 fetchValid", {31'h0, bus.fetchValid}, 32'h0);
        step(0, 0, 0, 1, 32'h2008_0001);
        check("lat c3 fetchValid", {31'h0, bus.fetchValid}, 32'h1);
        check("lat c3 pcAdd4IF", bus.pcAdd4IF, 32'h4);
        check("lat c3 instructionIF", bus.instructionIF, 32'h2008_0001);

        // Advance to pc 0x10, then stall on the delivered word
        step(0, 0, 0, 1, 32'h0000_0004);
        step(0, 0, 0, 1, 32'h0000_0008);
        step(0, 0, 0, 1, 32'h0000_000C);
        step(1, 0, 0, 1, 32'h8C08_0000);
        check("stall deliver memAddr", bus.memAddr, 32'h10);
        check("stall deliver instructionIF", bus.instructionIF, 32'h8C08_0000);
        step(1, 0, 0, 0, 32'h0);
        check("hold memReq", {31'h0, bus.memReq}, 32'h0);
        check("hold instructionIF", bus.instructionIF, 32'h8C08_0000);
        step(1, 0, 0, 1, 32'hBAD0_0002);
        check("hold ignores memReady", bus.instructionIF, 32'h8C08_0000);
        step(0, 0, 0, 0, 32'h0);
        check("hold release fetchValid", {31'h0, bus.fetchValid}, 32'h1);
        step(0, 0, 0, 1, 32'h0000_0014);
        check("after stall memAddr", bus.memAddr, 32'h14);
        step(0, 0, 0, 1, 32'h0000_0018);
        step(0, 0, 0, 1, 32'h0000_001C);

        // Redirect with the request at 0x20 still pending
        step(0, 1, 32'h0040_0103, 0, 32'h0);
        check("sq0 memAddr", bus.memAddr, 32'h20);
        check("sq0 fetchValid", {31'h0, bus.fetchValid}, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("sq1 memReq", {31'h0, bus.memReq}, 32'h1);
        check("sq1 memAddr", bus.memAddr, 32'h20);
        step(0, 0, 0, 1, 32'hDEAD_BEEF);
        check("sq2 fetchValid", {31'h0, bus.fetchValid}, 32'h0);
        check("sq2 instructionIF", bus.instructionIF, 32'h0);
        step(1, 0, 0, 1, 32'h1234_5678);
        check("sq target memAddr", bus.memAddr, 32'h0040_0100);

        // Redirect and stall together in HOLD
        step(1, 1, 32'h0000_0200, 0, 32'h0);
        check("hold redirect fetchValid", {31'h0, bus.fetchValid}, 32'h0);
        check("hold redirect instructionIF", bus.instructionIF, 32'h0);
        step(0, 1, 32'hFFFF_FFFC, 1, 32'hAAAA_AAAA);
        check("hold redirect next memAddr", bus.memAddr, 32'h200);
        check("answered redirect fetchValid", {31'h0, bus.fetchValid}, 32'h0);

        // Wrap at the top of the address space
        step(0, 0, 0, 1, 32'h1111_2222);
        check("wrap memAddr", bus.memAddr, 32'hFFFF_FFFC);
        check("wrap pcAdd4IF", bus.pcAdd4IF, 32'h0);
        check("wrap fetchValid", {31'h0, bus.fetchValid}, 32'h1);

        // Repeated redirects while squashing: the latest one wins
        step(0, 1, 32'h0000_0100, 0, 32'h0);
        check("wrap next memAddr", bus.memAddr, 32'h0);
        step(0, 1, 32'h0000_0303, 0, 32'h0);
        step(0, 0, 0, 1, 32'h5555_5555);
        step(0, 1, 32'h0000_0400, 0, 32'h0);
        check("latest redirect memAddr", bus.memAddr, 32'h300);
        step(0, 1, 32'h0000_0500, 1, 32'h6666_6666);
        step(0, 0, 0, 0, 32'h0);
        check("redirect on drain memAddr", bus.memAddr, 32'h500);

        // Reset while the request at 0x500 is outstanding
        #1;
        reset = 1'b1;
        #1;
        check("mid reset memAddr", bus.memAddr, 32'h0);
        check("mid reset memReq", {31'h0, bus.memReq}, 32'h1);
        check("mid reset fetchValid", {31'h0, bus.fetchValid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        step(0, 0, 0, 1, 32'h2008_0001);
        check("after mid reset instructionIF", bus.instructionIF, 32'h2008_0001);
        check("after mid reset pcAdd4IF", bus.pcAdd4IF, 32'h4);

        // Mixed traffic checked by the model only
        for (int i = 0; i < 60; i++)
            step(($urandom % 4) == 0, ($urandom % 6) == 0, $urandom,
                 ($urandom % 2) == 1, $urandom);

        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
